qpp_interleaver_stream: RTL and testbench
=========================================

# qpp_interleaver_stream

Streaming LTE turbo-coder QPP interleaver for the coder/interleaver datapath. It accepts a code block byte-wise, stores it in one of two ping-pong bit banks, then emits two bit-serial streams: the block in natural order (c_i) and the same block in interleaved order (c_π(i)). π(i) = (f1·i + f2·i²) mod K is generated recursively, with no wide remap network. It generalises the fixed two-size interleaver to parameterised block sizes and QPP coefficients, with valid/ready handshakes and double buffering.

## Interface
- KMAX, 6144, bank depth in bits; max supported K
- K_A, 1056, block size selected when k_sel=0 (multiple of 8, ≤ KMAX)
- F1_A, 17, QPP f1 for K_A
- F2_A, 66, QPP f2 for K_A
- K_B, 6144, block size selected when k_sel=1
- F1_B, 263, QPP f1 for K_B
- F2_B, 480, QPP f2 for K_B
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- k_sel  in  1  block-size select, sampled with the first byte of a block
- in_byte  in  8  input data byte; bit j of byte b is c[8b+j]
- in_valid  in  1  in_byte is valid
- in_ready  out  1  block can accept a byte
- out_ci  out  1  natural-order bit c[i]
- out_cpi  out  1  interleaved bit c[π(i)]
- out_valid  out  1  out_ci/out_cpi are valid
- out_ready  in  1  downstream accepts the current bit pair
- out_last  out  1  marks i = K−1
- out_k_sel  out  1  k_sel of the block being emitted

## Operation
- Two banks, KMAX bits each. Per-bank state: EMPTY, FILLING, FULL, DRAINING; per-bank stored k_sel.
- Write side: pointer wb (reset 0), byte counter wcnt. in_ready = (state[wb] ∈ {EMPTY, FILLING}), combinational.
- Byte accepted when in_valid && in_ready. EMPTY→FILLING on the first byte, which also latches k_sel. Bits are written at 8·wcnt+j.
- On the byte with wcnt = K/8−1: bank → FULL, wcnt ← 0, wb toggles.
- k_sel changes while a block is FILLING are ignored.
- Read side: pointer rb (reset 0). When state[rb] = FULL, it moves to DRAINING and starts at i=0, π=0, g=(f1+f2) mod K.
- Each emitted pair advances i←i+1, π←(π+g) mod K, g←(g+2f2 mod K) mod K.
- All modular adds: operands are < K, so one conditional subtract. Widths are clog2(KMAX). 2f2 mod K is a per-size constant.
- After emitting the pair with i=K−1 (out_last=1): bank → EMPTY, rb toggles.
- Both banks are independent. A write-side and a read-side transition in the same cycle (on different banks) both take effect.
- Reset: both banks EMPTY, wb=rb=0, all counters 0, stored contents don't-care, no partial block is emitted.

## Timing
- Reset values: out_valid=0, out_ci=0, out_cpi=0, out_last=0, out_k_sel=0. in_ready=1 immediately after reset deasserts.
- Output registers are updated when !out_valid || out_ready; otherwise they and i/π/g hold. There are no bubbles while out_ready=1.
- Latency: the last byte is accepted at edge t, the bank is FULL after t, and out_valid=1 with i=0 after edge t+2.
- Throughput: 1 byte/cycle in, 1 bit pair/cycle out.
- Consecutive blocks: the first pair of the next bank follows the out_last pair with at most 1 idle cycle.
- in_ready=0 while both banks are FULL/DRAINING. It returns to 1 in the cycle after the draining bank's out_last pair is accepted.
- Asynchronous reset mid-block: outputs go to reset values immediately and input state is discarded.

## Test plan
- K_A block, all bytes 0 except byte 10 = 0x08 (c[83]=1) -> out_cpi=1 only at i=1; out_ci=1 only at i=83; out_last at i=1055; out_k_sel=0.
- K_B block, byte 92 = 0x80 (c[743]) and byte 305 = 0x40 (c[2446]) -> out_cpi=1 exactly at i=1 and i=2; out_ci=1 at i=743 and i=2446.
- K_A block, only c[49]=1 -> out_cpi=1 only at i=1055 (with out_last). K_B block, only c[217]=1 -> out_cpi=1 only at i=6143.
- Three back-to-back blocks (A, B, A) with in_valid held high -> in_ready drops after the second block is filled; the streams arrive in order with correct out_k_sel; each stream has exactly K pairs.
- Random out_ready toggling -> out_ci/out_cpi/out_last are held stable while out_valid && !out_ready; the emitted sequence matches the reference model bit-exactly.
- reset_n pulsed after 50 bytes of a block -> out_valid=0 and in_ready=1 immediately. A fresh full block is then emitted correctly from i=0 with no residue.

Source files
------------

// File: rtl/qpp_interleaver_stream.sv
// Streaming LTE QPP interleaver: byte-wise fill into ping-pong bit banks, then
// bit-serial natural and interleaved streams with pi(i) generated recursively.
`timescale 1ns/1ps

module qpp_interleaver_stream #(
  parameter int KMAX = 6144,
  parameter int K_A  = 1056,
  parameter int F1_A = 17,
  parameter int F2_A = 66,
  parameter int K_B  = 6144,
  parameter int F1_B = 263,
  parameter int F2_B = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       k_sel,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_ci,
  output logic       out_cpi,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_k_sel
);

  localparam int W  = $clog2(KMAX);
  localparam int BW = W - 3;

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  localparam logic [W:0]    KA_V    = (W+1)'(K_A);
  localparam logic [W:0]    KB_V    = (W+1)'(K_B);
  localparam logic [W-1:0]  KA_M1   = W'(K_A - 1);
  localparam logic [W-1:0]  KB_M1   = W'(K_B - 1);
  localparam logic [W-1:0]  G0_A    = W'((F1_A + F2_A) % K_A);
  localparam logic [W-1:0]  G0_B    = W'((F1_B + F2_B) % K_B);
  localparam logic [W-1:0]  D_A     = W'((2 * F2_A) % K_A);
  localparam logic [W-1:0]  D_B     = W'((2 * F2_B) % K_B);
  localparam logic [BW-1:0] LASTB_A = BW'(K_A / 8 - 1);
  localparam logic [BW-1:0] LASTB_B = BW'(K_B / 8 - 1);

  // Both operands are already reduced, so a single conditional subtract suffices.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W:0]   k);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= k) s = s - k;
    return s[W-1:0];
  endfunction

  logic [KMAX-1:0] mem_q [2];

  logic [1:0]    state_q [2];
  logic [1:0]    state_d [2];
  logic [1:0]    ksel_q, ksel_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [BW-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]  i_q, i_d;
  logic [W-1:0]  pi_q, pi_d;
  logic [W-1:0]  g_q, g_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_ci_q, out_ci_d;
  logic          out_cpi_q, out_cpi_d;
  logic          out_last_q, out_last_d;
  logic          out_k_sel_q, out_k_sel_d;

  logic          rb_n;
  logic [1:0]    wr_state;
  logic          wr_fire;
  logic          wr_ksel;
  logic          wr_last;
  logic          rd_ksel;
  logic [W:0]    rd_k;
  logic [W-1:0]  rd_km1;
  logic [W-1:0]  rd_d;
  logic          load_en;
  logic          load;
  logic          fire_last;

  assign rb_n     = ~rb_q;
  assign wr_state = state_q[wb_q];
  assign in_ready = (wr_state == ST_EMPTY) || (wr_state == ST_FILLING);
  assign wr_fire  = in_valid && in_ready;
  // k_sel is only honoured on the first byte; later changes are ignored.
  assign wr_ksel  = (wr_state == ST_EMPTY) ? k_sel : ksel_q[wb_q];
  assign wr_last  = wr_fire && (wcnt_q == (wr_ksel ? LASTB_B : LASTB_A));

  assign rd_ksel   = ksel_q[rb_q];
  assign rd_k      = rd_ksel ? KB_V  : KA_V;
  assign rd_km1    = rd_ksel ? KB_M1 : KA_M1;
  assign rd_d      = rd_ksel ? D_B   : D_A;
  assign load_en   = !out_valid_q || out_ready;
  assign load      = load_en && busy_q;
  assign fire_last = out_valid_q && out_ready && out_last_q;

  always_comb begin
    state_d     = state_q;
    ksel_d      = ksel_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    i_d         = i_q;
    pi_d        = pi_q;
    g_d         = g_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_ci_d    = out_ci_q;
    out_cpi_d   = out_cpi_q;
    out_last_d  = out_last_q;
    out_k_sel_d = out_k_sel_q;

    if (wr_fire) begin
      ksel_d[wb_q] = wr_ksel;
      if (wr_last) begin
        state_d[wb_q] = ST_FULL;
        wcnt_d        = '0;
        wb_d          = ~wb_q;
      end else begin
        state_d[wb_q] = ST_FILLING;
        wcnt_d        = wcnt_q + BW'(1);
      end
    end

    if (load_en) begin
      out_valid_d = load;
      if (load) begin
        out_ci_d    = mem_q[rb_q][i_q];
        out_cpi_d   = mem_q[rb_q][pi_q];
        out_last_d  = (i_q == rd_km1);
        out_k_sel_d = rd_ksel;
        i_d         = i_q + W'(1);
        pi_d        = mod_add(pi_q, g_q, rd_k);
        g_d         = mod_add(g_q, rd_d, rd_k);
        if (i_q == rd_km1) busy_d = 1'b0;
      end else begin
        out_ci_d   = 1'b0;
        out_cpi_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end

    // Starting the other bank on the same edge keeps the inter-block gap to one cycle.
    if (fire_last) begin
      state_d[rb_q] = ST_EMPTY;
      rb_d          = rb_n;
      if (state_q[rb_n] == ST_FULL) begin
        state_d[rb_n] = ST_DRAINING;
        i_d           = '0;
        pi_d          = '0;
        g_d           = ksel_q[rb_n] ? G0_B : G0_A;
        busy_d        = 1'b1;
      end
    end else if (!busy_q && (state_q[rb_q] == ST_FULL)) begin
      state_d[rb_q] = ST_DRAINING;
      i_d           = '0;
      pi_d          = '0;
      g_d           = rd_ksel ? G0_B : G0_A;
      busy_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wb_q][{wcnt_q, 3'b000} +: 8] <= in_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q[0]  <= ST_EMPTY;
      state_q[1]  <= ST_EMPTY;
      ksel_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      i_q         <= '0;
      pi_q        <= '0;
      g_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ci_q    <= 1'b0;
      out_cpi_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_k_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ksel_q      <= ksel_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      i_q         <= i_d;
      pi_q        <= pi_d;
      g_q         <= g_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_ci_q    <= out_ci_d;
      out_cpi_q   <= out_cpi_d;
      out_last_q  <= out_last_d;
      out_k_sel_q <= out_k_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ci    = out_ci_q;
  assign out_cpi   = out_cpi_q;
  assign out_last  = out_last_q;
  assign out_k_sel = out_k_sel_q;

endmodule

// File: tb/tb_qpp_interleaver_stream.sv
// Scoreboard bench for qpp_interleaver_stream: a direct-formula QPP model feeds
// an expected-pair queue that the output monitor drains.
`timescale 1ns/1ps

module tb_qpp_interleaver_stream;

  localparam int KMAX = 6144;
  localparam int K_A  = 1056;
  localparam int F1_A = 17;
  localparam int F2_A = 66;
  localparam int K_B  = 6144;
  localparam int F1_B = 263;
  localparam int F2_B = 480;

  logic       clk;
  logic       reset_n;
  logic       k_sel;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       out_ci;
  logic       out_cpi;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_k_sel;

  qpp_interleaver_stream #(
    .KMAX(KMAX), .K_A(K_A), .F1_A(F1_A), .F2_A(F2_A),
    .K_B(K_B), .F1_B(F1_B), .F2_B(F2_B)
  ) dut (
    .clk(clk), .reset_n(reset_n), .k_sel(k_sel), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .out_ci(out_ci),
    .out_cpi(out_cpi), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_k_sel(out_k_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [3:0] sb[$];

  bit rand_ready = 0;
  bit gap_en = 0;
  bit after_last = 0;
  int idle_cnt = 0;
  int pair_idx = 0;
  int streams = 0;
  int ci_cnt, cpi_cnt, last_pos;
  int ci_pos[2];
  int cpi_pos[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushExpected(input logic ks, input logic [KMAX-1:0] data);
    longint k, f1, f2, p;
    k  = ks ? K_B : K_A;
    f1 = ks ? F1_B : F1_A;
    f2 = ks ? F2_B : F2_A;
    for (longint i = 0; i < k; i++) begin
      p = (f1 * i + f2 * i * i) % k;
      sb.push_back({data[int'(i)], data[int'(p)], (i == k - 1), ks});
    end
  endtask

  task automatic applyStimulus(input logic ks, input logic [KMAX-1:0] data,
                               input bit keep_valid, input bit toggle_ks,
                               input int max_bytes, output int stalls);
    int nbytes;
    int guard;
    nbytes = (ks ? K_B : K_A) / 8;
    if (max_bytes > 0) nbytes = max_bytes;
    stalls = 0;
    for (int b = 0; b < nbytes; b++) begin
      guard = 0;
      forever begin
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = data[8*b +: 8];
        k_sel    = (b != 0 && toggle_ks) ? ~ks : ks;
        if (in_ready) begin
          @(posedge clk);
          break;
        end
        stalls++;
        guard++;
        if (guard > 20000) begin
          checkOutput("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    if (max_bytes == 0) pushExpected(ks, data);
    if (!keep_valid) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_budget", (n < budget), 1);
  endtask

  // Output monitor: drives out_ready and compares every presented pair, stalled or not.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (reset_n) begin
        if (out_valid) begin
          if (after_last) begin
            if (gap_en) checkOutput("gap_le1", (idle_cnt <= 1), 1);
            after_last = 0;
          end
          if (sb.size() == 0) begin
            checkOutput("extra_pair", 1, 0);
          end else begin
            checkOutput("pair", {out_ci, out_cpi, out_last, out_k_sel}, sb[0]);
            if (out_ready) begin
              void'(sb.pop_front());
              if (pair_idx == 0) begin
                ci_cnt = 0; cpi_cnt = 0; last_pos = -1;
                ci_pos[0] = -1; ci_pos[1] = -1; cpi_pos[0] = -1; cpi_pos[1] = -1;
              end
              if (out_ci) begin
                if (ci_cnt < 2) ci_pos[ci_cnt] = pair_idx;
                ci_cnt++;
              end
              if (out_cpi) begin
                if (cpi_cnt < 2) cpi_pos[cpi_cnt] = pair_idx;
                cpi_cnt++;
              end
              if (out_last) begin
                last_pos   = pair_idx;
                pair_idx   = 0;
                streams++;
                after_last = 1;
                idle_cnt   = 0;
              end else begin
                pair_idx++;
              end
            end
          end
        end else if (after_last) begin
          idle_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [KMAX-1:0] d;
    int st1, st2, st3, s0, n;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    k_sel    = 1'b0;
    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_ci", out_ci, 0);
    checkOutput("rst_out_cpi", out_cpi, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_k_sel", out_k_sel, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] K_A block with c[83]=1, k_sel toggled after first byte");
    d = '0; d[83] = 1'b1;
    applyStimulus(1'b0, d, 0, 1, 0, st1);
    checkOutput("lat_t1", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_t2", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_t3", out_valid, 1);
    waitDrain(20000);
    checkOutput("a83_ci_cnt", ci_cnt, 1);
    checkOutput("a83_ci_pos", ci_pos[0], 83);
    checkOutput("a83_cpi_cnt", cpi_cnt, 1);
    checkOutput("a83_cpi_pos", cpi_pos[0], 1);
    checkOutput("a83_last_pos", last_pos, 1055);

    $display("[TB] K_B block with c[743] and c[2446]");
    d = '0; d[92*8 +: 8] = 8'h80; d[305*8 +: 8] = 8'h40;
    applyStimulus(1'b1, d, 0, 0, 0, st1);
    waitDrain(20000);
    checkOutput("b2_cpi_cnt", cpi_cnt, 2);
    checkOutput("b2_cpi_pos0", cpi_pos[0], 1);
    checkOutput("b2_cpi_pos1", cpi_pos[1], 2);
    checkOutput("b2_ci_pos0", ci_pos[0], 743);
    checkOutput("b2_ci_pos1", ci_pos[1], 2446);
    checkOutput("b2_last_pos", last_pos, 6143);

    $display("[TB] interleaved-order boundary blocks");
    d = '0; d[49] = 1'b1;
    applyStimulus(1'b0, d, 0, 0, 0, st1);
    waitDrain(20000);
    checkOutput("a49_cpi_cnt", cpi_cnt, 1);
    checkOutput("a49_cpi_pos", cpi_pos[0], 1055);
    d = '0; d[217] = 1'b1;
    applyStimulus(1'b1, d, 0, 1, 0, st1);
    waitDrain(20000);
    checkOutput("b217_cpi_cnt", cpi_cnt, 1);
    checkOutput("b217_cpi_pos", cpi_pos[0], 6143);

    $display("[TB] back-to-back A, B, A");
    s0 = streams;
    after_last = 0;
    gap_en = 1;
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b0, d, 1, 0, 0, st1);
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b1, d, 1, 0, 0, st2);
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b0, d, 0, 0, 0, st3);
    checkOutput("b2b_no_stall_1", st1, 0);
    checkOutput("b2b_no_stall_2", st2, 0);
    checkOutput("b2b_stall_3", (st3 > 0), 1);
    waitDrain(30000);
    gap_en = 0;
    checkOutput("b2b_streams", streams - s0, 3);

    $display("[TB] random out_ready backpressure");
    rand_ready = 1;
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b0, d, 0, 0, 0, st1);
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b0, d, 0, 1, 0, st1);
    waitDrain(30000);
    rand_ready = 0;

    $display("[TB] reset pulse mid-block");
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b0, d, 0, 0, 0, st1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre_reset_valid", out_valid, 1);
    applyStimulus(1'b1, d, 0, 0, 50, st1);
    #2;
    reset_n = 1'b0;
    sb.delete();
    pair_idx   = 0;
    after_last = 0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_last", out_last, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s0 = streams;
    for (int b = 0; b < KMAX / 8; b++) d[8*b +: 8] = 8'($urandom);
    applyStimulus(1'b1, d, 0, 0, 0, st1);
    waitDrain(20000);
    checkOutput("post_rst_streams", streams - s0, 1);
    checkOutput("post_rst_last_pos", last_pos, 6143);

    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
